// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_checker
// Purpose  : Self-running checker for a 4-input / 1-output combinational
//            block. Sweeps vectors 0..15 on {pp,qq,rr,ss}, holds each for
//            HOLD_CYCLES cycles, samples tt on the last cycle of the window
//            and compares it against EXPECTED[vector].
// Ports    : clk, rst_n (async, active-low), start (1-cycle sweep request),
//            tt (DUT output) -> pp,qq,rr,ss (vector to DUT), busy, done,
//            pass, err_count[4:0], first_fail[3:0], fail_valid,
//            fail_map[15:0]
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECTED    = 16'h4644
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        tt,
  output logic        pp,
  output logic        qq,
  output logic        rr,
  output logic        ss,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid,
  output logic [15:0] fail_map
);

  // Hold counter needs at least one bit even when HOLD_CYCLES == 1.
  localparam int              c_HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HW-1:0] c_LAST = c_HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_vec;
  logic [c_HW-1:0]   r_hold_cnt;
  logic              r_busy;
  logic              r_done;
  logic [4:0]        r_err_count;
  logic [3:0]        r_first_fail;
  logic              r_fail_valid;
  logic [15:0]       r_fail_map;

  logic              w_mismatch;

  assign w_mismatch = tt ^ EXPECTED[r_vec];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 4'd0;
      r_hold_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_count  <= 5'd0;
      r_first_fail <= 4'd0;
      r_fail_valid <= 1'b0;
      r_fail_map   <= 16'h0000;
    end else begin
      case (r_state)
        // A start from DONE behaves exactly like a start from IDLE.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_RUN;
            r_vec        <= 4'd0;
            r_hold_cnt   <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err_count  <= 5'd0;
            r_first_fail <= 4'd0;
            r_fail_valid <= 1'b0;
            r_fail_map   <= 16'h0000;
          end
        end
        S_RUN: begin
          if (r_hold_cnt == c_LAST) begin
            // End of window: sample tt for the vector currently driven.
            if (w_mismatch) begin
              r_err_count       <= r_err_count + 5'd1;
              r_fail_map[r_vec] <= 1'b1;
              if (!r_fail_valid) begin
                r_first_fail <= r_vec;
                r_fail_valid <= 1'b1;
              end
            end
            r_hold_cnt <= '0;
            // Last vector stays on the outputs (4'hF) through DONE.
            if (r_vec == 4'hF) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec <= r_vec + 4'd1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {pp, qq, rr, ss} = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_done && (r_err_count == 5'd0);
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;
  assign fail_valid = r_fail_valid;
  assign fail_map   = r_fail_map;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_checker
// Purpose  : Scoreboard bench for truth_table_checker. Two checkers are
//            instantiated (HOLD_CYCLES=20 and HOLD_CYCLES=1), each driving a
//            modelled DUT whose output is EXPECTED[vec] XOR a fault mask.
//            Stimulus pushes the predicted sweep result; a monitor pops it
//            when done rises and also tracks the driven vector sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  localparam int          H0 = 20;
  localparam int          H1 = 1;
  localparam logic [15:0] E0 = 16'h4644;
  localparam logic [15:0] E1 = 16'hB38E;

  typedef struct {
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        fv;
    logic [15:0] map;
    logic        pass;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [15:0] f0 = 16'h0, f1 = 16'h0;

  logic pp0, qq0, rr0, ss0, busy0, done0, pass0, fv0;
  logic pp1, qq1, rr1, ss1, busy1, done1, pass1, fv1;
  logic [4:0] ec0, ec1;
  logic [3:0] ff0, ff1;
  logic [15:0] fm0, fm1;
  logic tt0, tt1;
  logic [3:0] v0, v1;

  assign v0  = {pp0, qq0, rr0, ss0};
  assign v1  = {pp1, qq1, rr1, ss1};
  assign tt0 = E0[v0] ^ f0[v0];
  assign tt1 = E1[v1] ^ f1[v1];

  always #5 clk = ~clk;

  truth_table_checker #(.HOLD_CYCLES(H0), .EXPECTED(E0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .tt(tt0),
    .pp(pp0), .qq(qq0), .rr(rr0), .ss(ss0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .first_fail(ff0), .fail_valid(fv0), .fail_map(fm0)
  );

  truth_table_checker #(.HOLD_CYCLES(H1), .EXPECTED(E1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tt(tt1),
    .pp(pp1), .qq(qq1), .rr(rr1), .ss(ss1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_fail(ff1), .fail_valid(fv1), .fail_map(fm1)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: every faulty vector is a mismatch; the sweep lasts 16 windows.
  function automatic exp_t model(input logic [15:0] mask, input int h);
    exp_t e;
    e.cnt = 5'd0;
    e.ff  = 4'd0;
    e.fv  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        e.cnt++;
        if (!e.fv) begin
          e.ff = 4'(i);
          e.fv = 1'b1;
        end
      end
    end
    e.map  = mask;
    e.pass = (mask == 16'h0);
    e.len  = 16 * h;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int   bc0 = 0, bc1 = 0;
  logic pd0 = 1'b0, pd1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done0 && !pd0) begin
      if (q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("dut0_busy_len", bc0, e.len);
        chk("dut0_err_count", ec0, e.cnt);
        chk("dut0_first_fail", ff0, e.ff);
        chk("dut0_fail_valid", fv0, e.fv);
        chk("dut0_fail_map", fm0, e.map);
        chk("dut0_pass", pass0, e.pass);
      end
    end
    if (busy0) begin
      chk("dut0_vec_seq", v0, bc0 / H0);
      bc0++;
    end else bc0 = 0;
    pd0 = done0;

    if (done1 && !pd1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1_busy_len", bc1, e.len);
        chk("dut1_err_count", ec1, e.cnt);
        chk("dut1_first_fail", ff1, e.ff);
        chk("dut1_fail_valid", fv1, e.fv);
        chk("dut1_fail_map", fm1, e.map);
        chk("dut1_pass", pass1, e.pass);
      end
    end
    if (busy1) begin
      chk("dut1_vec_seq", v1, bc1 / H1);
      bc1++;
    end else bc1 = 0;
    pd1 = done1;
  end

  // ---------------- stimulus ----------------
  task automatic sweep(input int which, input logic [15:0] mask, input bit extra);
    int h;
    bit seen;
    h = (which == 0) ? H0 : H1;
    if (which == 0) begin
      f0 = mask;
      q0.push_back(model(mask, h));
    end else begin
      f1 = mask;
      q1.push_back(model(mask, h));
    end
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    // Results must be cleared on the start edge, whether coming from IDLE or DONE.
    if (which == 0) chk("dut0_start_clear", {busy0, done0, pass0, fv0, ec0, fm0}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0});
    else            chk("dut1_start_clear", {busy1, done1, pass1, fv1, ec1, fm1}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0});
    if (extra) begin
      repeat (98) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 16 * h + 40; i++) begin
      if ((which == 0) ? done0 : done1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("sweep_done_timeout", seen, 1'b1);
    repeat (3) @(negedge clk);
    if (which == 0) chk("dut0_done_vec_f", {done0, v0}, {1'b1, 4'hF});
    else            chk("dut1_done_vec_f", {done1, v1}, {1'b1, 4'hF});
  endtask

  initial begin
    bit hit;
    repeat (2) @(negedge clk);
    chk("reset_outputs_dut0", {v0, busy0, done0, pass0, ec0, ff0, fv0, fm0}, 32'h0);
    chk("reset_outputs_dut1", {v1, busy1, done1, pass1, ec1, ff1, fv1, fm1}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold_dut0", {v0, busy0, done0, ec0, fm0}, 32'h0);

    sweep(0, 16'h0000, 1'b0);          // golden DUT
    sweep(0, E0, 1'b0);                // tt stuck at 0
    sweep(0, 16'hFFFF, 1'b0);          // inverted output
    sweep(0, 16'h0810, 1'b1);          // extra start mid-sweep is ignored
    sweep(0, ($urandom & $urandom) & 16'hFFFF, 1'b0);  // restart straight from DONE
    for (int k = 0; k < 3; k++) sweep(0, $urandom & 16'hFFFF, 1'b0);

    // Asynchronous reset while vector 7 is driven.
    f0 = 16'h0;
    q0.push_back(model(16'h0, H0));
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (v0 == 4'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_vec7", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_dut0", {v0, busy0, done0, pass0, ec0, ff0, fv0, fm0}, 32'h0);
    q0.delete();                       // aborted sweep produces no result
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 16'h0000, 1'b0);

    sweep(1, 16'h0200, 1'b0);          // single fault at vector 9, one-cycle windows
    for (int k = 0; k < 12; k++) sweep(1, $urandom & 16'hFFFF, 1'b0);
    sweep(1, 16'h0000, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-running hardware checker for a 4-input, 1-output combinational function block under test (DUT).
- Drives all 16 input vectors {pp,qq,rr,ss} in ascending order, holding each for a programmable number of cycles.
- Samples the DUT output tt at the end of each hold window and compares it against a parameterized expected truth table.
- Reports a pass/fail summary, a mismatch count, the first failing vector and a per-vector failure map. Replaces the manual sweep-and-inspect-waveform flow with an on-chip verdict.

Parameters:
- HOLD_CYCLES, 20: cycles each vector is held; legal range >= 1.
- EXPECTED, 16'h4644: expected tt per vector; bit index = {pp,qq,rr,ss}. The default has ones at vectors 2, 6, 9, 10 and 14.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- tt  input  1  DUT output, combinational from pp/qq/rr/ss.
- pp  output  1  vector bit 3 (MSB) to the DUT.
- qq  output  1  vector bit 2 to the DUT.
- rr  output  1  vector bit 1 to the DUT.
- ss  output  1  vector bit 0 (LSB) to the DUT.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  5  number of mismatching vectors, 0..16.
- first_fail  output  4  lowest failing vector index; valid when fail_valid=1.
- fail_valid  output  1  at least one mismatch has been recorded.
- fail_map  output  16  bit i set if vector i mismatched.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: {pp,qq,rr,ss}=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0, fail_map=0.
  - Internal vec and hold_cnt are cleared.
  - Reset mid-sweep aborts the sweep; no partial results are retained.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold their reset values.
  - start=1 at a clock edge moves to RUN.
  - On that edge: vec=0, hold_cnt=0, busy=1, and all result registers are cleared.
- RUN:
  - {pp,qq,rr,ss} = vec, registered and glitch-free. The vector changes only at window boundaries.
  - hold_cnt increments every cycle.
  - At the edge where hold_cnt==HOLD_CYCLES-1, tt is compared with EXPECTED[vec].
  - On a mismatch at that edge:
    - err_count increments.
    - fail_map[vec] is set.
    - If fail_valid==0, first_fail=vec and fail_valid=1.
  - At the same edge, if vec==15: go to DONE, busy=0, done=1. Otherwise vec increments and hold_cnt returns to 0.
  - Each vector is presented for exactly HOLD_CYCLES cycles. Total busy time = 16*HOLD_CYCLES cycles.
  - The sample for the last vector and the transition to DONE occur on the same edge, so results are final in the first DONE cycle.
  - start is ignored during RUN.
- DONE:
  - Results are held stable.
  - pass is asserted combinationally from done and err_count.
  - {pp,qq,rr,ss} holds 4'hF.
  - start=1 behaves exactly as start in IDLE: clears results and restarts from vec=0. done and pass drop on that edge.
- HOLD_CYCLES=1: the vector changes every cycle and is sampled in the same cycle it is driven (DUT is combinational, single-cycle settle).
- Widths:
  - err_count is 5 bits and cannot overflow (max 16).
  - hold_cnt width = clog2(HOLD_CYCLES) with a minimum of 1 bit.
- tt is sampled directly with no synchronizer; the DUT must be in the clk domain.

Test Plan:
1. Golden DUT (tt = EXPECTED[{pp,qq,rr,ss}]), HOLD_CYCLES=20, pulse start -> busy=1 for 320 cycles; then done=1, pass=1, err_count=0, fail_valid=0, fail_map=16'h0000.
2. DUT tt stuck at 0 -> err_count=5, first_fail=2, fail_valid=1, fail_map=16'h4644, pass=0.
3. DUT output inverted -> err_count=16, first_fail=0, fail_map=16'hFFFF, pass=0.
4. Sequence check, HOLD_CYCLES=20:
   - {pp,qq,rr,ss} steps 0,1,...,15, changing every 20 cycles.
   - An extra start pulse at cycle 100 is ignored: sweep length and results are unchanged.
   - start pulsed in DONE restarts the sweep with results cleared.
5. Assert rst_n=0 asynchronously while vec=7 -> all outputs read 0 immediately without a clock edge. After release and start, the sweep begins at vec=0 with clean counts.
6. HOLD_CYCLES=1, DUT with a single fault at vector 9 -> sweep completes in 16 cycles; err_count=1, first_fail=9, fail_map=16'h0200, pass=0.
